// File: rtl/morse_msg_sequencer_if.sv
// Message-buffer and playback signals of the morse message sequencer.
// Master drives writes/controls, slave is the sequencer itself.
interface morse_msg_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          unit_tick_i;
  logic          wr_en_i;
  logic [1:0]    wr_sym_i;
  logic          clr_i;
  logic          play_i;
  logic          repeat_i;
  logic          abort_i;
  logic          live_key_i;
  logic          key_o;
  logic          busy_o;
  logic          done_o;
  logic          full_o;
  logic [CW-1:0] count_o;

  modport master (
    output unit_tick_i, wr_en_i, wr_sym_i, clr_i, play_i, repeat_i, abort_i, live_key_i,
    input  key_o, busy_o, done_o, full_o, count_o
  );

  modport slave (
    input  unit_tick_i, wr_en_i, wr_sym_i, clr_i, play_i, repeat_i, abort_i, live_key_i,
    output key_o, busy_o, done_o, full_o, count_o
  );
endinterface

// File: rtl/morse_msg_sequencer.sv
// Stored-message morse player: buffers dit/dah/gap symbols and keys them out
// on unit ticks, handing the key line back to the live keyer whenever idle.
//
// state | meaning
// IDLE  | buffer writable, key_o follows live_key_i
// LOAD  | one cycle, decode mem[rd_ptr] into MARK/SPACE and unit count
// MARK  | key down, counting units
// SPACE | key up, counting units (inter-element or symbol gap)
// DONE  | one-cycle completion pulse
module morse_msg_sequencer #(
  parameter int DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  morse_msg_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    units_q, units_d;
  logic [1:0]    mem [DEPTH];
  logic          wr_ok;
  logic          full;
  logic          at_end;
  logic [1:0]    sym_rd;

  assign full   = (count_q == CW'(DEPTH));
  assign at_end = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
  assign sym_rd = mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      units_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      units_q  <= units_d;
    end
  end

  // Buffer contents survive reset; count_q==0 makes them unreachable anyway.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[count_q[AW-1:0]] <= bus.wr_sym_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    units_d  = units_q;
    wr_ok    = 1'b0;

    if (bus.clr_i) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      units_d  = '0;
    end else if (bus.abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      units_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_en_i && !full) begin
            wr_ok   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (bus.play_i && (count_q != '0)) begin
            state_d  = LOAD;
            rd_ptr_d = '0;
          end
        end
        LOAD: begin
          case (sym_rd)
            2'b00:   begin state_d = MARK;  units_d = 3'd1; end
            2'b01:   begin state_d = MARK;  units_d = 3'd3; end
            2'b10:   begin state_d = SPACE; units_d = 3'd2; end
            default: begin state_d = SPACE; units_d = 3'd6; end
          endcase
        end
        MARK: begin
          if (bus.unit_tick_i) begin
            if (units_q == 3'd1) begin
              state_d = SPACE;
              units_d = 3'd1;
            end else begin
              units_d = units_q - 3'd1;
            end
          end
        end
        SPACE: begin
          if (bus.unit_tick_i) begin
            if (units_q == 3'd1) begin
              // repeat_i is only consulted here, at the end of a pass
              if (at_end) begin
                if (bus.repeat_i) begin
                  state_d  = LOAD;
                  rd_ptr_d = '0;
                end else begin
                  state_d = DONE;
                end
              end else begin
                state_d  = LOAD;
                rd_ptr_d = rd_ptr_q + AW'(1);
              end
              units_d = '0;
            end else begin
              units_d = units_q - 3'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy_o  = (state_q == LOAD) || (state_q == MARK) || (state_q == SPACE);
  assign bus.done_o  = (state_q == DONE) && !bus.clr_i;
  assign bus.full_o  = full;
  assign bus.count_o = count_q;
  assign bus.key_o   = (state_q == MARK) ? 1'b1 :
                       (state_q == IDLE) ? bus.live_key_i : 1'b0;
endmodule

// File: doc/morse_msg_sequencer.md
MORSE_MSG_SEQUENCER -- requirements
Module: morse_msg_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of message symbol entries (power of two).
REQ-002 SHALL have port clk_i, input, 1, the single system clock.
REQ-003 SHALL have port rstn_i, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port unit_tick_i, input, 1, a one-cycle strobe marking each dit-unit boundary at the selected WPM.
REQ-005 SHALL have port wr_en_i, input, 1, which appends wr_sym_i to the message buffer.
REQ-006 SHALL have port wr_sym_i, input, 2, the symbol code: 00 dit, 01 dah, 10 letter gap, 11 word gap.
REQ-007 SHALL have port clr_i, input, 1, which empties the buffer and aborts playback.
REQ-008 SHALL have port play_i, input, 1, a start-playback pulse.
REQ-009 SHALL have port repeat_i, input, 1, which loops the message (beacon mode) while high.
REQ-010 SHALL have port abort_i, input, 1, which signals live paddle activity (break-in).
REQ-011 SHALL have port live_key_i, input, 1, the live key from the keyer core.
REQ-012 SHALL have port key_o, output, 1, the muxed key line to the morse/buzzer path.
REQ-013 SHALL have port busy_o, output, 1, which is high while playback is active.
REQ-014 SHALL have port done_o, output, 1, a one-cycle pulse on normal playback completion.
REQ-015 SHALL have port full_o, output, 1, which is high when the buffer holds DEPTH entries.
REQ-016 SHALL have port count_o, output, log2(DEPTH)+1, the number of stored symbols.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, MARK, SPACE, DONE; busy_o SHALL be high in LOAD, MARK and SPACE.
REQ-018 SHALL accept wr_en_i only in IDLE with full_o low: mem[count] <= wr_sym_i and count increments; otherwise the write is silently dropped.
REQ-019 SHALL give clr_i priority over wr_en_i and play_i in the same cycle: count <= 0, read pointer <= 0, FSM <= IDLE, done_o stays low.
REQ-020 SHALL move IDLE->LOAD on play_i when count>0, with the read pointer set to 0; play_i when count==0 or when not in IDLE SHALL be ignored.
REQ-021 SHALL spend exactly one cycle in LOAD decoding mem[rd_ptr]: dit->MARK with units=1, dah->MARK with units=3, letter gap->SPACE with units=2, word gap->SPACE with units=6.
REQ-022 SHALL decrement the 3-bit unit counter only on unit_tick_i in MARK or SPACE; ticks in LOAD, IDLE or DONE SHALL be ignored.
REQ-023 SHALL go MARK->SPACE with units=1 (inter-element space) on a tick with units==1.
REQ-024 SHALL, on SPACE with units==1 and a tick: if rd_ptr==count-1, go to LOAD with rd_ptr=0 when repeat_i is high, else to DONE; otherwise rd_ptr++ and go to LOAD.
REQ-025 SHALL make DONE last one cycle with done_o=1, then go to IDLE.
REQ-026 SHALL drive key_o = 1 in MARK; 0 in LOAD, SPACE and DONE; and live_key_i (combinational pass-through) in IDLE.
REQ-027 SHALL, on abort_i high in any non-IDLE state, enter IDLE on the next edge with no done_o, giving key_o = live_key_i from that cycle onward.
REQ-028 SHALL treat abort_i as winning over a simultaneous unit-tick transition, and clr_i as winning over abort_i.
REQ-029 SHALL leave buffer contents unchanged by playback and abort, so the message can be replayed.
REQ-030 SHALL evaluate repeat_i only at the end-of-message decision point, so lowering it mid-message finishes the current pass, then DONE.

Reset
REQ-031 SHALL, on rstn_i low, asynchronously force: FSM=IDLE, count=0, rd_ptr=0, units=0, busy_o=0, done_o=0, full_o=0, count_o=0, and key_o=live_key_i.
REQ-032 SHALL not reset buffer contents; they are unreadable until rewritten, because count=0.
REQ-033 SHALL, on reset asserted mid-playback, drop key_o within the reset assertion regardless of clock.

Verification
REQ-034 Write dit, dah, letter gap; play_i; tick every 4 clk -> key_o high 1 unit, low 1, high 3, low 1, low 2, then done_o pulse; 8 units total.
REQ-035 Write 16 symbols, then a 17th -> full_o=1, count_o=16, 17th dropped; clr_i with wr_en_i in the same cycle -> count_o=0.
REQ-036 repeat_i=1 with message dah, word gap -> key pattern repeats (3 on, 7 off) for 3 passes with no done_o; drop repeat_i -> current pass ends, then a single done_o.
REQ-037 abort_i pulse during the 2nd unit of a dah -> busy_o=0 next cycle, key_o tracks live_key_i toggles, no done_o; replay -> full message intact.
REQ-038 play_i with count_o=0 -> busy_o stays 0, no done_o; wr_en_i while busy -> count_o unchanged.
REQ-039 rstn_i low asynchronously mid-MARK -> key_o follows live_key_i and busy_o=0 before the next clk edge; count_o=0 after release.
